// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    // Two baud periods at 100 MHz / 9600.
    localparam int BUSY_TIMEOUT_DEF = 20832;
    localparam int BAUD_DIV         = 10416;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // One extra bit so ptr + k never overflows before the wrap.
    logic [IW:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(NREQ))
                pos = pos - (IW+1)'(NREQ);
            if (!any && req[pos[IW-1:0]]) begin
                any                = 1'b1;
                idx                = pos[IW-1:0];
                grant[pos[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NREQ requesters into a single UART transmitter.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0][7:0]     req_data,
    output logic [NREQ-1:0]          req_ack,
    output logic                     uart_start,
    output logic [7:0]               uart_data,
    input  logic                     uart_ready,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int IW = $clog2(NREQ);

    state_t          state, state_nx;
    logic [IW-1:0]   ptr, ptr_nx, grant_nx, win_idx;
    logic [NREQ-1:0] win_oh, ack_nx;
    logic            win_any, start_nx, err_nx;
    logic [14:0]     cnt, cnt_nx;
    logic [7:0]      hold_nx;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (win_oh),
        .idx   (win_idx),
        .any   (win_any)
    );

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        hold_nx  = uart_data;
        grant_nx = grant_id;
        ack_nx   = '0;
        start_nx = 1'b0;
        err_nx   = timeout_err;
        case (state)
            IDLE: begin
                if (uart_ready && win_any) begin
                    state_nx = ISSUE;
                    ack_nx   = win_oh;
                    start_nx = 1'b1;
                    hold_nx  = req_data[win_idx];
                    grant_nx = win_idx;
                    ptr_nx   = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
                end
            end
            ISSUE: begin
                state_nx = WAIT_BUSY;
                cnt_nx   = '0;
            end
            WAIT_BUSY: begin
                // A transmitter that never goes busy drops the byte rather than stalling everyone.
                if (!uart_ready)
                    state_nx = WAIT_DONE;
                else if (cnt == 15'(BUSY_TIMEOUT-1)) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else
                    cnt_nx = cnt + 1'b1;
            end
            WAIT_DONE: begin
                if (uart_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            uart_data   <= '0;
            grant_id    <= '0;
            req_ack     <= '0;
            uart_start  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            cnt         <= cnt_nx;
            uart_data   <= hold_nx;
            grant_id    <= grant_nx;
            req_ack     <= ack_nx;
            uart_start  <= start_nx;
            busy        <= (state_nx != IDLE);
            timeout_err <= err_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised scoreboard bench for uart_tx_arbiter with a simple UART busy/ready stub.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int BT   = 16;
    localparam int IW   = 2;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0][7:0] req_data;
    logic [NREQ-1:0]      req_ack;
    logic                 uart_start;
    logic [7:0]           uart_data;
    logic                 uart_ready;
    logic [IW-1:0]        grant_id;
    logic                 busy;
    logic                 timeout_err;

    always #5 CLK = ~CLK;

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(BT)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .uart_start  (uart_start),
        .uart_data   (uart_data),
        .uart_ready  (uart_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [7:0]    data;
    } txn_t;

    txn_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         mptr = 0;
    int         mdl_rem[NREQ];
    logic [7:0] mdl_data[NREQ];
    int         load_rem[NREQ];
    logic [7:0] load_data[NREQ];
    int         load_seq = 0;
    int         rem[NREQ];
    int         seen_seq = 0;
    int         start_cnt = 0;
    int         glitch = 0;
    logic [7:0] last_data = 8'h00;

    // UART stub: ready drops 5 cycles after a start and stays low for 40 cycles.
    logic ext_busy = 1'b0;
    logic stub_en = 1'b1;
    logic stub_ready = 1'b1;
    int   dly = 0;
    int   lo = 0;
    assign uart_ready = ext_busy ? 1'b0 : stub_ready;

    always @(negedge CLK) begin
        if (!stub_en) begin
            dly = 0; lo = 0; stub_ready = 1'b1;
        end else if (lo > 0) begin
            lo = lo - 1;
            if (lo == 0) stub_ready = 1'b1;
        end else if (dly > 0) begin
            dly = dly - 1;
            if (dly == 0) begin stub_ready = 1'b0; lo = 40; end
        end else if (uart_start)
            dly = 5;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp_v);
        end
    endtask

    // Each requester keeps req_valid high until it has been acked rem[i] times.
    task automatic drive_loop();
        forever begin
            @(negedge CLK);
            for (int i = 0; i < NREQ; i++)
                if (req_ack[i] && rem[i] > 0) rem[i]--;
            if (load_seq != seen_seq) begin
                seen_seq = load_seq;
                for (int i = 0; i < NREQ; i++)
                    if (load_rem[i] > 0) begin
                        rem[i]      = load_rem[i];
                        req_data[i] = load_data[i];
                    end
            end
            for (int i = 0; i < NREQ; i++)
                req_valid[i] = (rem[i] > 0);
        end
    endtask

    task automatic mon_loop();
        txn_t t;
        forever begin
            @(negedge CLK);
            if (uart_start) begin
                start_cnt++;
                last_data = uart_data;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_start: grant_id=%0d data='h%0h, expected no transfer", grant_id, uart_data);
                end else begin
                    t = exp_q.pop_front();
                    chk("grant_id", 32'(grant_id), 32'(t.id));
                    chk("uart_data", 32'(uart_data), 32'(t.data));
                    chk("req_ack", 32'(req_ack), 32'(1) << t.id);
                end
            end else begin
                if (req_ack != '0) glitch++;
                if (busy && uart_data != last_data) glitch++;
            end
        end
    endtask

    // Reference: each decision serves the first pending requester at or after the pointer.
    task automatic model_push();
        int   r[NREQ];
        int   left;
        txn_t t;
        left = 0;
        for (int i = 0; i < NREQ; i++) begin r[i] = mdl_rem[i]; left += r[i]; end
        while (left > 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (mptr + k) % NREQ;
                if (r[i] > 0) begin
                    t.id = IW'(i); t.data = mdl_data[i];
                    exp_q.push_back(t);
                    r[i]--; left--;
                    mptr = (i + 1) % NREQ;
                    break;
                end
            end
        end
    endtask

    task automatic clear_mdl();
        for (int i = 0; i < NREQ; i++) begin mdl_rem[i] = 0; mdl_data[i] = 8'h00; end
    endtask

    task automatic round();
        model_push();
        for (int i = 0; i < NREQ; i++) begin load_rem[i] = mdl_rem[i]; load_data[i] = mdl_data[i]; end
        load_seq++;
    endtask

    function automatic bit rem_any();
        rem_any = 1'b0;
        for (int i = 0; i < NREQ; i++) if (rem[i] > 0) rem_any = 1'b1;
    endfunction

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || rem_any()) && n < 3000) begin
            @(negedge CLK); n++;
        end
        chk({nm, "_drained"}, 32'(exp_q.size()), 0);
        chk({nm, "_busy_low"}, 32'(busy), 0);
        repeat (3) @(negedge CLK);
    endtask

    task automatic wait_start(input string nm);
        int n;
        n = 0;
        while (!uart_start && n < 300) begin @(negedge CLK); n++; end
        chk(nm, 32'(uart_start), 1);
    endtask

    task automatic do_reset();
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
        mptr = 0;
    endtask

    initial begin
        int s0, n;
        req_valid = '0;
        req_data  = '0;
        fork
            drive_loop();
            mon_loop();
        join_none

        repeat (3) @(negedge CLK);
        chk("reset_outputs", 32'({req_ack, uart_start, uart_data, grant_id, busy, timeout_err}), 0);
        RST = 1'b0;

        // single byte
        clear_mdl(); mdl_rem[0] = 1; mdl_data[0] = 8'h41; round();
        wait_idle("single");

        // fairness from reset
        do_reset();
        clear_mdl();
        for (int i = 0; i < NREQ; i++) begin mdl_rem[i] = 1; mdl_data[i] = 8'h10 + 8'(i); end
        round(); wait_idle("fair");

        // wrap between requesters 1 and 3
        clear_mdl(); mdl_rem[1] = 3; mdl_data[1] = 8'hA1; mdl_rem[3] = 3; mdl_data[3] = 8'hA3;
        round(); wait_idle("wrap");

        // random rounds
        repeat (20) begin
            clear_mdl();
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 1) == 1) begin
                    mdl_rem[i]  = $urandom_range(1, 3);
                    mdl_data[i] = 8'($urandom);
                end
            if (mdl_rem[0] + mdl_rem[1] + mdl_rem[2] + mdl_rem[3] == 0) begin
                n = $urandom_range(0, NREQ-1);
                mdl_rem[n] = 1; mdl_data[n] = 8'($urandom);
            end
            round(); wait_idle("rand");
        end

        // transmitter busy from elsewhere: no grant until ready, then start one cycle later
        clear_mdl(); mdl_rem[0] = 1; mdl_data[0] = 8'h5A;
        ext_busy = 1'b1; s0 = start_cnt; round();
        repeat (100) @(negedge CLK);
        chk("no_grant_while_busy", 32'(start_cnt - s0), 0);
        ext_busy = 1'b0;
        @(negedge CLK);
        chk("start_after_ready", 32'(uart_start), 1);
        wait_idle("busy_start");

        // timeout: transmitter never goes busy
        stub_en = 1'b0;
        clear_mdl(); mdl_rem[2] = 1; mdl_data[2] = 8'hC3; round();
        wait_start("timeout_issue_seen");
        repeat (BT) @(negedge CLK);
        chk("timeout_not_early", 32'(timeout_err), 0);
        @(negedge CLK);
        chk("timeout_err_set", 32'(timeout_err), 1);
        chk("timeout_back_idle", 32'(busy), 0);
        stub_en = 1'b1;
        clear_mdl(); mdl_rem[0] = 1; mdl_data[0] = 8'h77; round();
        wait_idle("after_timeout");
        chk("timeout_sticky", 32'(timeout_err), 1);

        // reset in WAIT_DONE; requester 2 keeps its request up across the reset
        clear_mdl(); mdl_rem[2] = 1; mdl_data[2] = 8'h99; model_push();
        for (int i = 0; i < NREQ; i++) begin load_rem[i] = 0; load_data[i] = 8'h00; end
        load_rem[2] = 2; load_data[2] = 8'h99; load_seq++;
        wait_start("mid_issue_seen");
        n = 0;
        while (uart_ready && n < 50) begin @(negedge CLK); n++; end
        chk("mid_ready_low", 32'(uart_ready), 0);
        repeat (2) @(negedge CLK);
        chk("mid_busy", 32'(busy), 1);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_outputs", 32'({req_ack, uart_start, uart_data, grant_id, busy, timeout_err}), 0);
        RST = 1'b0;
        mptr = 0;
        clear_mdl(); mdl_rem[2] = 1; mdl_data[2] = 8'h99; mdl_rem[3] = 1; mdl_data[3] = 8'h3C;
        model_push();
        for (int i = 0; i < NREQ; i++) begin load_rem[i] = 0; load_data[i] = 8'h00; end
        load_rem[3] = 1; load_data[3] = 8'h3C; load_seq++;
        wait_idle("rst_regrant");

        chk("ack_and_data_hold", 32'(glitch), 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
